// File: rtl/hazard_fwd_unit.sv
// Operand bypass select and pipeline hazard detection at the ID/EX boundary,
// with a register scoreboard tracking outstanding long-latency writes.
module hazard_fwd_unit #(
    parameter int unsigned  NSRC     = 2,
    parameter int unsigned  NFWD     = 2,
    parameter int unsigned  AW       = 5,
    parameter int unsigned  MAX_PEND = 4,
    parameter int unsigned  SCW      = 32,
    localparam int unsigned SW       = $clog2(NFWD + 2),
    localparam int unsigned PCW      = $clog2(MAX_PEND + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [NSRC*AW-1:0] src_addr,
    input  logic [NSRC-1:0]    src_used,
    input  logic [AW-1:0]      dst_addr,
    input  logic               dst_we,
    input  logic               id_is_lat,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*AW-1:0] fwd_rd,
    input  logic               ld_s1,
    input  logic               lat_issue,
    input  logic [AW-1:0]      lat_issue_rd,
    input  logic               lat_done,
    input  logic [AW-1:0]      lat_done_rd,
    output logic [NSRC*SW-1:0] fwd_sel,
    output logic               stall,
    output logic [PCW-1:0]     pend_cnt,
    output logic               pend_full,
    output logic [SCW-1:0]     stall_cnt,
    output logic               sb_err
);
    localparam int unsigned NREG = 2 ** AW;

    // Bit 0 exists only to keep indexing uniform; x0 is never set.
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_nx;
    logic [AW-1:0]   src;
    logic            load_use;
    logic            raw_hit;
    logic            waw_hit;
    logic            struct_hit;
    logic            issue_v;
    logic            done_v;
    logic            done_ok;
    logic            done_same;
    logic            issue_ok;
    logic            inc;
    logic            err_nx;
    logic [PCW-1:0]  pend_cnt_nx;

    // Per-operand bypass select and stall detection.
    always_comb begin
        fwd_sel    = '0;
        load_use   = 1'b0;
        raw_hit    = 1'b0;
        waw_hit    = 1'b0;
        struct_hit = 1'b0;
        src        = '0;
        for (int i = 0; i < NSRC; i++) begin
            src = src_addr[i*AW +: AW];
            if (id_valid && src_used[i] && src != '0) begin
                if (lat_done && lat_done_rd == src) begin
                    fwd_sel[i*SW +: SW] = SW'(NFWD + 1);
                end else begin
                    // Walk oldest to youngest so the youngest match is kept.
                    for (int k = NFWD - 1; k >= 0; k--) begin
                        if (fwd_we[k] && fwd_rd[k*AW +: AW] == src)
                            fwd_sel[i*SW +: SW] = SW'(k + 1);
                    end
                end
                if (ld_s1 && fwd_we[0] && fwd_rd[AW-1:0] == src)
                    load_use = 1'b1;
                if (sb[src] && !(lat_done && lat_done_rd == src))
                    raw_hit = 1'b1;
            end
        end
        waw_hit    = dst_we && dst_addr != '0 && sb[dst_addr]
                     && !(lat_done && lat_done_rd == dst_addr);
        struct_hit = id_is_lat && pend_full && !lat_done;
        stall      = id_valid && (load_use || raw_hit || waw_hit || struct_hit);
    end

    // Scoreboard, occupancy and error next-state.
    always_comb begin
        issue_v     = lat_issue && lat_issue_rd != '0;
        done_v      = lat_done && lat_done_rd != '0;
        done_ok     = done_v && sb[lat_done_rd];
        done_same   = done_ok && lat_done_rd == lat_issue_rd;
        // A slot frees only on a genuine completion, so the count never overruns.
        issue_ok    = issue_v && (!pend_full || done_ok);
        inc         = issue_ok && (!sb[lat_issue_rd] || done_same);
        err_nx      = sb_err
                      || (issue_v && sb[lat_issue_rd] && !done_same)
                      || (done_v && !sb[lat_done_rd])
                      || (issue_v && pend_full && !lat_done);
        sb_nx       = sb;
        if (done_ok)
            sb_nx[lat_done_rd] = 1'b0;
        if (issue_ok)
            sb_nx[lat_issue_rd] = 1'b1;
        pend_cnt_nx = pend_cnt;
        if (inc && !done_ok)
            pend_cnt_nx = pend_cnt + PCW'(1);
        else if (!inc && done_ok)
            pend_cnt_nx = pend_cnt - PCW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb        <= '0;
            pend_cnt  <= '0;
            pend_full <= 1'b0;
            stall_cnt <= '0;
            sb_err    <= 1'b0;
        end else begin
            sb        <= sb_nx;
            pend_cnt  <= pend_cnt_nx;
            pend_full <= (pend_cnt_nx == PCW'(MAX_PEND));
            sb_err    <= err_nx;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + SCW'(1);
        end
    end
endmodule
